// File: rtl/irq_sched_pkg.sv
// Shared constants for irq_sched: register map, FSM states and ISR bit positions.
// No logic or latency here. Backpressure does not apply.
package irq_sched_pkg;

  localparam logic [3:0] ADDR_MASK = 4'd0;
  localparam logic [3:0] ADDR_PEND = 4'd4;
  localparam logic [3:0] ADDR_MODE = 4'd8;
  localparam logic [3:0] ADDR_ISR  = 4'd12;

  localparam int ISR_VALID = 31;
  localparam int ISR_TMO   = 30;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  function automatic logic [31:0] isr_word(input logic valid, input logic tmo, input logic [2:0] id);
    isr_word            = '0;
    isr_word[ISR_VALID] = valid;
    isr_word[ISR_TMO]   = tmo;
    isr_word[2:0]       = id;
  endfunction

endpackage

// File: rtl/irq_sched_if.sv
// Device-bus register port plus CPU req/ack handshake of the interrupt scheduler.
// Wires only. The CPU paces requests through ack_i; the register bus never stalls.
interface irq_sched_if;
  logic [3:0]  ADD_I;
  logic        WE_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        irq_o;
  logic [2:0]  irq_id_o;
  logic        ack_i;
  logic        busy_o;

  modport master (output ADD_I, WE_I, DAT_I, ack_i, input DAT_O, irq_o, irq_id_o, busy_o);
  modport slave  (input ADD_I, WE_I, DAT_I, ack_i, output DAT_O, irq_o, irq_id_o, busy_o);
endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set bit wins. Purely combinational, zero latency.
// No handshake, so no backpressure.
module irq_prio_enc #(
  parameter int NSRC = 6
) (
  input  logic [NSRC-1:0] vec,
  output logic [2:0]      id,
  output logic            any
);

  always_comb begin
    id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (vec[i]) id = 3'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/irq_sched.sv
// Interrupt scheduler: pend latch, mask, fixed priority, req/ack to CPU, EOI via ISR write; IRQ_SCHED_ACK_TMO_EN adds an ack timeout.
// Latency: pending source to irq_o 2 cycles; irq_o holds (no new winner) until ack, unpend or timeout.
module irq_sched
  import irq_sched_pkg::*;
#(
  parameter int NSRC    = 6,
  parameter int ACK_TMO = 255
) (
  input  logic            clk,
  input  logic            reset,
  irq_sched_if.slave      bus,
  input  logic [NSRC-1:0] src_irq_i
);

  logic [NSRC-1:0] mask_q, mode_q, pend_q, hist_q;
  logic [NSRC-1:0] elig, rise, pend_clr, grant_clr, pend_d;
  logic [7:0]      elig8;
  logic [2:0]      id_q, isr_id_q, win_id;
  logic            win_any, grant, tmo_bit, unused_bits;
  logic            wr_mask, wr_pend, wr_mode, wr_isr;
  state_e          state_q, state_d;

  assign wr_mask = bus.WE_I && (bus.ADD_I == ADDR_MASK);
  assign wr_pend = bus.WE_I && (bus.ADD_I == ADDR_PEND);
  assign wr_mode = bus.WE_I && (bus.ADD_I == ADDR_MODE);
  assign wr_isr  = bus.WE_I && (bus.ADD_I == ADDR_ISR);

  assign elig  = pend_q & mask_q;
  assign elig8 = 8'(elig);

  irq_prio_enc #(.NSRC(NSRC)) u_enc (
    .vec (elig),
    .id  (win_id),
    .any (win_any)
  );

`ifdef IRQ_SCHED_ACK_TMO_EN
  localparam logic [7:0] TMO_LAST = 8'(ACK_TMO - 1);
  logic [7:0] tmo_cnt_q;
  logic       tmo_q, tmo_hit;
  assign tmo_bit     = tmo_q;
  assign unused_bits = ^bus.DAT_I[31:NSRC];
`else
  assign tmo_bit     = 1'b0;
  assign unused_bits = ^{bus.DAT_I[31:NSRC], 8'(ACK_TMO)};
`endif

  always_comb begin
    state_d = state_q;
`ifdef IRQ_SCHED_ACK_TMO_EN
    tmo_hit = 1'b0;
`endif
    case (state_q)
      ST_IDLE:    if (win_any) state_d = ST_REQ;
      // Losing eligibility takes priority over a same-cycle ack.
      ST_REQ: begin
        if (!elig8[id_q])    state_d = ST_IDLE;
        else if (bus.ack_i)  state_d = ST_SERVICE;
`ifdef IRQ_SCHED_ACK_TMO_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d = ST_IDLE;
          tmo_hit = 1'b1;
        end
`endif
      end
      ST_SERVICE: if (wr_isr) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign grant     = (state_q == ST_REQ) && (state_d == ST_SERVICE);
  assign grant_clr = grant ? (({{(NSRC-1){1'b0}}, 1'b1} << id_q) & mode_q) : '0;
  assign rise      = src_irq_i & ~hist_q;
  assign pend_clr  = (wr_pend ? bus.DAT_I[NSRC-1:0] : '0) | grant_clr;
  // Edge bits: a new rising edge beats any clear in the same cycle.
  assign pend_d    = (mode_q & (rise | (pend_q & ~pend_clr))) | (~mode_q & src_irq_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q   <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      hist_q   <= '0;
      id_q     <= '0;
      isr_id_q <= '0;
      state_q  <= ST_IDLE;
    end else begin
      pend_q  <= pend_d;
      hist_q  <= src_irq_i;
      state_q <= state_d;
      if (wr_mask) mask_q <= bus.DAT_I[NSRC-1:0];
      if (wr_mode) mode_q <= bus.DAT_I[NSRC-1:0];
      if ((state_q == ST_IDLE) && win_any) id_q <= win_id;
      if (grant) isr_id_q <= id_q;
    end
  end

`ifdef IRQ_SCHED_ACK_TMO_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == ST_REQ) ? tmo_cnt_q + 8'd1 : 8'd0;
      if (tmo_hit)     tmo_q <= 1'b1;
      else if (wr_isr) tmo_q <= 1'b0;
    end
  end
`endif

  always_comb begin
    bus.DAT_O = '0;
    case (bus.ADD_I)
      ADDR_MASK: bus.DAT_O = 32'(mask_q);
      ADDR_PEND: bus.DAT_O = 32'(pend_q);
      ADDR_MODE: bus.DAT_O = 32'(mode_q);
      ADDR_ISR:  bus.DAT_O = isr_word(state_q == ST_SERVICE, tmo_bit, isr_id_q);
      default:   bus.DAT_O = '0;
    endcase
  end

  assign bus.irq_o    = (state_q == ST_REQ);
  assign bus.busy_o   = (state_q == ST_SERVICE);
  assign bus.irq_id_o = id_q;

endmodule

// File: doc/irq_sched.md
Name: irq_sched

Overview:
- Interrupt scheduler between the peripheral bus devices (timers and others) and the CPU's exception unit.
- Collects per-device IRQ lines and latches them as pending.
- Applies a mask, selects the highest-priority source and presents it to the CPU with a req/ack handshake.
- Tracks the in-service source until software writes end-of-interrupt (EOI).
- Registers are reached over the same simple device bus as the timers (ADD_I/WE_I/DAT_I/DAT_O).

Parameters:
- NSRC, 6, number of interrupt sources (1..8); source 0 is highest priority.
- ACK_TMO, 255, cycles to wait for CPU ack before abandoning a request (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ADD_I  in  4  byte register address: 0 MASK, 4 PEND, 8 MODE, 12 ISR.
- WE_I  in  1  write strobe, sampled on clk.
- DAT_I  in  32  write data.
- DAT_O  out  32  read data, combinational on ADD_I; unmapped addresses read 0.
- src_irq_i  in  NSRC  raw device IRQ lines (e.g. timer IRQ_O).
- irq_o  out  1  request to CPU.
- irq_id_o  out  3  source id of the current request/service.
- ack_i  in  1  one-cycle CPU acknowledge.
- busy_o  out  1  a source is in service (state SERVICE).

Behaviour:
- Registers:
  - MASK[NSRC-1:0]: 1 = source enabled.
  - MODE[NSRC-1:0]: 1 = edge-triggered (rising edge of src_irq_i), 0 = level.
  - PEND[NSRC-1:0]: read-only status; writing 1 to a bit clears that bit.
  - ISR: bit31 = in-service valid, bits[2:0] = id; any write to ISR = EOI.
  - Upper bits read 0.
- Reset (asynchronous, active-low): all registers, state and outputs clear.
  - MASK=0, MODE=0, PEND=0, state=IDLE, irq_o=0, irq_id_o=0, busy_o=0.
  - Edge-detect history flops = 0.
- Pending update, every cycle:
  - Level source: PEND bit = src_irq_i.
  - Edge source: PEND bit set on a 0->1 transition, held until cleared by W1C or by grant.
  - Same-cycle set and W1C on one bit: the set wins.
- Eligible = PEND & MASK. Winner = lowest-index eligible bit.
- State machine:
  - IDLE: if eligible != 0 -> REQ; latch winner into irq_id_o; irq_o=1 from the next cycle.
  - REQ: irq_o=1 and irq_id_o held stable.
    - ack_i=1 -> SERVICE; ISR={1,id}; edge-mode PEND bit auto-cleared that cycle.
    - If the latched source becomes masked or unpended before ack -> IDLE; irq_o drops next cycle; no ISR change.
  - SERVICE: irq_o=0, busy_o=1, no new request (non-nested).
    - Write to ISR -> IDLE; ISR valid cleared.
    - Earliest re-request: 1 cycle after EOI, i.e. 2 cycles from EOI write to irq_o.
- ack_i outside REQ is ignored.
- MASK and MODE writes take effect for arbitration on the next cycle.
- irq_id_o holds its last value in IDLE.
- Latency: eligible source to irq_o = 2 cycles (pend latch, then IDLE->REQ).

Optional Feature:
- Macro: IRQ_SCHED_ACK_TMO_EN.
- Defined:
  - An 8-bit wait counter runs in REQ.
  - After ACK_TMO cycles without ack -> IDLE, irq_o=0, sticky error bit ISR[30]=1.
  - ISR[30] is cleared by an ISR write.
- Undefined: no counter; REQ waits indefinitely; ISR[30] reads 0.

Decomposition:
- Shared package/header:
  - Register address constants (ADDR_MASK=0, ADDR_PEND=4, ADDR_MODE=8, ADDR_ISR=12).
  - State encodings IDLE/REQ/SERVICE.
  - ISR bit positions (VALID=31, TMO=30).
- One natural sub-module: irq_prio_enc, a combinational fixed-priority encoder (NSRC-bit vector -> 3-bit id + any flag).
- Edge detect, registers and FSM stay in irq_sched.

Test Plan:
- Reset, then MASK=0x3F, MODE=0; drive src_irq_i=0x04 -> irq_o=1 two cycles later, irq_id_o=2; ack -> busy_o=1, ISR reads 0x80000002.
- Sources 1 and 4 pending together -> id 1 first; ack, EOI -> id 4 requested 2 cycles after the EOI write.
- MODE=0x01, single-cycle pulse on src 0 -> PEND[0] stays 1 after the pulse; ack clears PEND[0]; second pulse during SERVICE is latched and requested after EOI.
- In REQ with id 3, write MASK=0 -> irq_o drops next cycle, state IDLE, ISR valid stays 0.
- Drop reset mid-SERVICE -> all outputs 0 immediately (asynchronous); after release, MASK reads 0 and no request occurs.
- With IRQ_SCHED_ACK_TMO_EN, ACK_TMO=4, no ack -> irq_o falls after 4 REQ cycles; ISR[30]=1; ISR write clears it.
